// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding,
// port select codes and the common counter width.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCESS = 2'b01,
      DONE   = 2'b10
   } state_t;

   localparam logic SEL_IF = 1'b0;
   localparam logic SEL_D  = 1'b1;

   localparam int CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter holding the remaining access latency.
// Ports: i_load/i_val preset the count, i_dec steps it down, o_zero flags 0.
module lat_counter
   import mem_arb_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_dec,
   input  logic [CNT_W-1:0] i_val,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_val;
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter/sequencer for the shared fetch/data memory port.
// Ports: if_req/d_req/d_we in; mem_sel/mem_en/mem_we, if_ack/d_ack, busy out.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic if_req,
   input  logic d_req,
   input  logic d_we,
   output logic mem_sel,
   output logic mem_en,
   output logic mem_we,
   output logic if_ack,
   output logic d_ack,
   output logic busy
);

   localparam logic [CNT_W-1:0] LP_LAT_M1 = CNT_W'(MEM_LAT - 1);
   localparam logic [CNT_W-1:0] LP_SMAX   = CNT_W'(STARVE_MAX);

   state_t           r_state;
   state_t           w_next;
   logic             r_sel;
   logic             r_we;
   logic [CNT_W-1:0] r_starve;

   logic w_req;
   logic w_force_if;
   logic w_grant_d;
   logic w_load;
   logic w_dec;
   logic w_zero;

   lat_counter u_lat (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_load),
      .i_dec  (w_dec),
      .i_val  (LP_LAT_M1),
      .o_zero (w_zero)
   );

   always_comb begin
      w_req      = if_req | d_req;
      // fetch overrides data only after STARVE_MAX back-to-back data wins
      w_force_if = if_req & d_req & (r_starve == LP_SMAX);
      w_grant_d  = d_req & ~w_force_if;
      w_load     = 1'b0;
      w_dec      = 1'b0;
      w_next     = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_req) begin
               w_load = 1'b1;
               w_next = ACCESS;
            end
         end
         ACCESS: begin
            w_dec = 1'b1;
            if (w_zero) begin
               w_next = DONE;
            end
         end
         DONE: begin
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sel    <= SEL_IF;
         r_we     <= 1'b0;
         r_starve <= '0;
      end else if (w_load) begin
         r_sel <= w_grant_d ? SEL_D : SEL_IF;
         r_we  <= w_grant_d & d_we;
         // only data wins over a waiting fetch count toward starvation
         if (w_grant_d && if_req) begin
            if (r_starve != LP_SMAX) begin
               r_starve <= r_starve + 1'b1;
            end
         end else begin
            r_starve <= '0;
         end
      end
   end

   assign mem_sel = r_sel;
   assign mem_en  = (r_state == ACCESS);
   assign mem_we  = (r_state == ACCESS) & r_we;
   assign if_ack  = (r_state == DONE) & (r_sel == SEL_IF);
   assign d_ack   = (r_state == DONE) & (r_sel == SEL_D);
   assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed checks of mem_port_arbiter against a
// transaction-level timing model.
module tb_mem_port_arbiter;

   localparam int LAT  = 2;
   localparam int SMAX = 4;

   logic clk;
   logic reset;
   logic if_req;
   logic d_req;
   logic d_we;
   logic mem_sel;
   logic mem_en;
   logic mem_we;
   logic if_ack;
   logic d_ack;
   logic busy;

   logic [5:0] w_outs;
   assign w_outs = {mem_sel, mem_en, mem_we, if_ack, d_ack, busy};

   mem_port_arbiter #(
      .MEM_LAT    (LAT),
      .STARVE_MAX (SMAX)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .if_req  (if_req),
      .d_req   (d_req),
      .d_we    (d_we),
      .mem_sel (mem_sel),
      .mem_en  (mem_en),
      .mem_we  (mem_we),
      .if_ack  (if_ack),
      .d_ack   (d_ack),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   // model: one access record, grant cycle g, winner and write flag
   bit   m_act    = 1'b0;
   int   m_g      = 0;
   logic m_sel    = 1'b0;
   logic m_we     = 1'b0;
   int   m_starve = 0;

   logic prev_en = 1'b0;
   logic q_sel[$];

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
      end
   endtask

   function automatic bit m_idle(int c);
      return !m_act || (c >= m_g + LAT + 2);
   endfunction

   // expected {sel,en,we,if_ack,d_ack,busy} from position in the access
   function automatic logic [5:0] exp_out(int c);
      if (m_idle(c)) return {m_sel, 5'b00000};
      if (c <= m_g + LAT) return {m_sel, 1'b1, m_we, 3'b001};
      return {m_sel, 2'b00, ~m_sel, m_sel, 1'b1};
   endfunction

   task automatic cycle(input string tag, input logic ir,
                        input logic dr, input logic we);
      if_req = ir;
      d_req  = dr;
      d_we   = we;
      if (m_idle(cyc) && (ir || dr)) begin
         m_act = 1'b1;
         m_g   = cyc;
         if (dr && !(ir && m_starve == SMAX)) begin
            m_sel    = 1'b1;
            m_we     = we;
            m_starve = ir ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
         end else begin
            m_sel    = 1'b0;
            m_we     = 1'b0;
            m_starve = 0;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      check(tag, {2'b00, w_outs}, {2'b00, exp_out(cyc)});
      if (mem_en && !prev_en) q_sel.push_back(mem_sel);
      prev_en = mem_en;
   endtask

   task automatic reset_mid();
      #3;
      reset = 1'b1;
      #1;
      check("rst_async", {2'b00, w_outs}, 8'd0);
      m_act    = 1'b0;
      m_sel    = 1'b0;
      m_starve = 0;
      prev_en  = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      check("rst_hold", {2'b00, w_outs}, 8'd0);
      reset = 1'b0;
   endtask

   initial begin
      logic exp_seq [6];
      reset  = 1'b0;
      if_req = 1'b0;
      d_req  = 1'b0;
      d_we   = 1'b0;
      #1;
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset", {2'b00, w_outs}, 8'd0);
      reset = 1'b0;

      // single fetch, requester drops req right after grant
      cycle("fetch", 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle("fetch", 1'b0, 1'b0, 1'b0);

      // contention: data wins, then the fetch still pending wins
      cycle("cont", 1'b1, 1'b1, 1'b1);
      cycle("cont", 1'b1, 1'b1, 1'b1);
      cycle("cont", 1'b1, 1'b1, 1'b1);
      cycle("cont", 1'b1, 1'b0, 1'b0);
      cycle("cont", 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cycle("cont", 1'b0, 1'b0, 1'b0);

      // starvation: both requests held continuously
      q_sel.delete();
      for (int i = 0; i < 26; i++) cycle("starve", 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle("starve", 1'b0, 1'b0, 1'b0);
      exp_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
      check("starve_n", 8'(q_sel.size()), 8'd7);
      for (int i = 0; i < 6; i++) begin
         if (i < q_sel.size()) begin
            check("starve_sel", {7'd0, q_sel[i]}, {7'd0, exp_seq[i]});
         end else begin
            check("starve_sel", 8'hff, {7'd0, exp_seq[i]});
         end
      end

      // d_we changing mid-read has no effect
      cycle("we_tog", 1'b0, 1'b1, 1'b0);
      cycle("we_tog", 1'b0, 1'b1, 1'b0);
      cycle("we_tog", 1'b0, 1'b1, 1'b1);
      cycle("we_tog", 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle("we_tog", 1'b0, 1'b0, 1'b0);

      // reset during second data access cycle, fetch held through it
      cycle("rst_d", 1'b1, 1'b1, 1'b1);
      cycle("rst_d", 1'b1, 1'b1, 1'b1);
      reset_mid();
      for (int i = 0; i < 6; i++) cycle("rst_f", 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) cycle("rst_f", 1'b0, 1'b0, 1'b0);

      // random traffic, occasional asynchronous reset
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            reset_mid();
         end else begin
            cycle("rand", 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)));
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
